// File: rtl/dmux_lane_collector_if.sv
// Bus bundle between the bit demux side and the word sink.
// master = the side that drives bits and out_ready, slave = the collector.
interface dmux_lane_collector_if #(
  parameter int WIDTH = 8
);
  logic             bit_valid;
  logic             sel;
  logic             a;
  logic             b;
  logic             out_ready;
  logic             out_valid;
  logic             out_lane;
  logic [WIDTH-1:0] out_data;
  logic             overflow;

  modport master (
    output bit_valid, sel, a, b, out_ready,
    input  out_valid, out_lane, out_data, overflow
  );

  modport slave (
    input  bit_valid, sel, a, b, out_ready,
    output out_valid, out_lane, out_data, overflow
  );
endinterface

// File: rtl/dmux_lane_collector.sv
// Reassembles the two demux lanes into WIDTH-bit words, buffers each lane in a
// DEPTH-entry FIFO and merges them round-robin onto one valid/ready output.
module dmux_lane_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  dmux_lane_collector_if.slave bus
);
  localparam int CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  // Stage 0: per-lane partial words (only the WIDTH-1 oldest bits are kept;
  // the final bit comes straight from the input on the completing edge).
  logic [WIDTH-2:0]  shift_p0 [2];
  logic [CNT_W-1:0]  cnt_p0   [2];

  // Per-lane word FIFOs.
  logic [WIDTH-1:0]  mem      [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [2];
  logic [PTR_W-1:0]  rd_ptr   [2];
  logic [FCNT_W-1:0] fcnt     [2];
  logic              rr;

  // Stage 1: output register.
  logic              out_valid_p1;
  logic              out_lane_p1;
  logic [WIDTH-1:0]  out_data_p1;
  logic              overflow_p1;

  logic [1:0]        lane_bit;
  logic [1:0]        done;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic [WIDTH-1:0]  word [2];
  logic              load;
  logic              any;
  logic              gnt;
  logic              drop;

  // Word completion, FIFO push/pop decisions and round-robin grant.
  always_comb begin
    lane_bit = {bus.b, bus.a};
    load     = !out_valid_p1 || bus.out_ready;
    nonempty = {fcnt[1] != '0, fcnt[0] != '0};
    any      = |nonempty;
    gnt      = (&nonempty) ? rr : nonempty[1];
    pop      = 2'b00;
    if (load && any) pop[gnt] = 1'b1;
    done     = 2'b00;
    push     = 2'b00;
    word[0]  = '0;
    word[1]  = '0;
    for (int l = 0; l < 2; l++) begin
      word[l] = {shift_p0[l], lane_bit[l]};
      done[l] = bus.bit_valid && (bus.sel == 1'(l)) &&
                (cnt_p0[l] == CNT_W'(WIDTH - 1));
      // A full FIFO still accepts the word if it is popped on this edge.
      push[l] = done[l] && ((fcnt[l] < FCNT_W'(DEPTH)) || pop[l]);
    end
    drop = |(done & ~push);
  end

  // Shift the incoming bit into the selected lane and count toward a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        shift_p0[l] <= '0;
        cnt_p0[l]   <= '0;
      end
    end else if (bus.bit_valid) begin
      shift_p0[bus.sel] <= word[bus.sel][WIDTH-2:0];
      cnt_p0[bus.sel]   <= done[bus.sel] ? '0 : cnt_p0[bus.sel] + CNT_W'(1);
    end
  end

  // FIFO storage write (contents need no reset; occupancy is tracked by fcnt).
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem[l][wr_ptr[l]] <= word[l];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
        fcnt[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l]) wr_ptr[l] <= wr_ptr[l] + PTR_W'(1);
        if (pop[l])  rd_ptr[l] <= rd_ptr[l] + PTR_W'(1);
        fcnt[l] <= fcnt[l] + FCNT_W'(push[l]) - FCNT_W'(pop[l]);
      end
    end
  end

  // Output register load, round-robin pointer update and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_p1 <= 1'b0;
      out_lane_p1  <= 1'b0;
      out_data_p1  <= '0;
      overflow_p1  <= 1'b0;
      rr           <= 1'b0;
    end else begin
      overflow_p1 <= drop;
      if (load) begin
        if (any) begin
          out_valid_p1 <= 1'b1;
          out_lane_p1  <= gnt;
          out_data_p1  <= mem[gnt][rd_ptr[gnt]];
          rr           <= ~gnt;
        end else begin
          out_valid_p1 <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_p1;
  assign bus.out_lane  = out_lane_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.overflow  = overflow_p1;
endmodule
